keccak_p400_engine: RTL and testbench

Keccak-p[400] permutation engine on port B of the EAGLE crypto dual-port state memory. It watches the memory's control byte for a CPU start request and snapshots the 400-bit state and round count. It then runs the requested rounds at one round per clock and writes the result back through the memory's port-B write path, with done set and start cleared.

---
 rtl/keccak_p400_pkg.sv | 41 ++++
 rtl/keccak_p400_round.sv | 52 +++++
 rtl/keccak_p400_engine.sv | 123 ++++++++++++
 tb/tb_keccak_p400_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_p400_pkg.sv
// Shared constants and types for the Keccak-p[400] engine on 16-bit lanes.
// Round constants are the low 16 bits of the Keccak RC; rho offsets are reduced mod 16.
package keccak_p400_pkg;

  localparam int LANE_W       = 16;
  localparam int STATE_W      = 400;
  localparam int FULL_ROUNDS  = 20;
  localparam int MAX_ROUNDS_DEF = 20;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_WRITE = 2'd2
  } eng_state_e;

  localparam logic [15:0] ROUND_CONST [0:19] = '{
    16'h0001, 16'h8082, 16'h808A, 16'h8000, 16'h808B,
    16'h0001, 16'h8081, 16'h8009, 16'h008A, 16'h0088,
    16'h8009, 16'h000A, 16'h808B, 16'h008B, 16'h8089,
    16'h8003, 16'h8002, 16'h0080, 16'h800A, 16'h000A
  };

  // Indexed [x][y].
  localparam int RHO_OFFSET [5][5] = '{
    '{ 0,  4,  3,  9,  2},
    '{ 1, 12, 10, 13,  2},
    '{14,  6, 11, 15, 13},
    '{12,  7,  9,  5,  8},
    '{11,  4,  7,  8, 14}
  };

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
    logic [31:0] t;
    t = {v, v} << n;
    return t[31:16];
  endfunction

endpackage

// File: rtl/keccak_p400_round.sv
// One Keccak-p[400] round (theta, rho, pi, chi, iota), purely combinational.
module keccak_p400_round
  import keccak_p400_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic [LANE_W-1:0]  rc_i,
  output logic [STATE_W-1:0] state_o
);

  logic [LANE_W-1:0] a [5][5];
  logic [LANE_W-1:0] b [5][5];
  logic [LANE_W-1:0] e [5][5];
  logic [LANE_W-1:0] c [5];
  logic [LANE_W-1:0] d [5];

  always_comb begin
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        a[x][y] = state_i[LANE_W*(5*y+x) +: LANE_W];
      end
    end

    for (int x = 0; x < 5; x++) begin
      c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
    end
    for (int x = 0; x < 5; x++) begin
      d[x] = c[(x+4)%5] ^ rotl16(c[(x+1)%5], 1);
    end

    // Theta and rho fused; pi is just the destination index.
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        b[y][(2*x+3*y)%5] = rotl16(a[x][y] ^ d[x], RHO_OFFSET[x][y]);
      end
    end

    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        e[x][y] = b[x][y] ^ (~b[(x+1)%5][y] & b[(x+2)%5][y]);
      end
    end
    e[0][0] = e[0][0] ^ rc_i;

    state_o = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        state_o[LANE_W*(5*y+x) +: LANE_W] = e[x][y];
      end
    end
  end

endmodule

// File: rtl/keccak_p400_engine.sv
// Keccak-p[400] engine on memory port B: snapshot on START, one round per clock, write back.
// Latency nr+1 cycles from START to write; the write strobe stalls while port A is writing.
module keccak_p400_engine
  import keccak_p400_pkg::*;
#(
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEF
) (
  input  logic               i_common_clk,
  input  logic               i_common_rst_n,
  input  logic [STATE_W-1:0] i_v_state_in,
  input  logic [7:0]         i_v_ctrl_reg,
  input  logic [7:0]         i_v_num_rounds,
  input  logic               i_cpu_wr_busy,
  output logic               o_b_wr,
  output logic [STATE_W-1:0] o_v_state_out,
  output logic [7:0]         o_v_ctrl_reg_out,
  output logic               o_busy
);

  localparam logic [7:0] MAX_NR8  = 8'(MAX_ROUNDS);
  localparam logic [4:0] MAX_NR5  = 5'(MAX_ROUNDS);
  localparam logic [4:0] FULL_NR5 = 5'(FULL_ROUNDS);

  eng_state_e         fsm_q, fsm_d;
  logic [STATE_W-1:0] st_q, st_d;
  logic [4:0]         idx_q, idx_d;
  logic [4:0]         nr_q, nr_d;

  logic [4:0]         nr_clamp;
  logic [LANE_W-1:0]  rc;
  logic [STATE_W-1:0] round_out;
  logic               start_req;

  assign start_req = i_v_ctrl_reg[CTRL_START_BIT];
  assign nr_clamp  = (i_v_num_rounds > MAX_NR8) ? MAX_NR5 : i_v_num_rounds[4:0];
  assign rc        = (idx_q < FULL_NR5) ? ROUND_CONST[idx_q] : '0;

  keccak_p400_round u_round (
    .state_i (st_q),
    .rc_i    (rc),
    .state_o (round_out)
  );

  always_ff @(posedge i_common_clk) begin
    if (!i_common_rst_n) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (start_req) begin
          fsm_d = (nr_clamp == 5'd0) ? ST_WRITE : ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (nr_q == 5'd1) begin
          fsm_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!i_cpu_wr_busy) begin
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_b_wr = 1'b0;
    o_busy = 1'b0;
    unique case (fsm_q)
      ST_ROUND: o_busy = 1'b1;
      ST_WRITE: begin
        o_busy = 1'b1;
        o_b_wr = !i_cpu_wr_busy;
      end
      default: ;
    endcase
  end

  // nr_q counts rounds remaining; idx_q selects the round constant.
  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    nr_d  = nr_q;
    if (fsm_q == ST_IDLE && start_req) begin
      st_d  = i_v_state_in;
      idx_d = FULL_NR5 - nr_clamp;
      nr_d  = nr_clamp;
    end else if (fsm_q == ST_ROUND) begin
      st_d  = round_out;
      idx_d = idx_q + 5'd1;
      nr_d  = nr_q - 5'd1;
    end
  end

  always_ff @(posedge i_common_clk) begin
    if (!i_common_rst_n) begin
      st_q  <= '0;
      idx_q <= '0;
      nr_q  <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      nr_q  <= nr_d;
    end
  end

  always_comb begin
    o_v_ctrl_reg_out = i_v_ctrl_reg;
    o_v_ctrl_reg_out[CTRL_DONE_BIT]  = 1'b1;
    o_v_ctrl_reg_out[CTRL_START_BIT] = 1'b0;
  end

  assign o_v_state_out = st_q;

endmodule

// File: tb/tb_keccak_p400_engine.sv
// Bench for keccak_p400_engine: models the state memory, drives START requests and
// checks every cycle against a Keccak-p[400] model built from derived constants.
module tb_keccak_p400_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [399:0] mem_state;
  logic [7:0]   mem_ctrl;
  logic [7:0]   mem_nr;
  logic         cpu_busy = 1'b0;
  logic         o_b_wr;
  logic [399:0] o_v_state_out;
  logic [7:0]   o_v_ctrl_reg_out;
  logic         o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic checking = 1'b0;

  int exp_from = 1, exp_to = 0, exp_wr = -1;
  int stall_from = 1 << 30, stall_cnt = 0;
  int op_t = 0;
  int wr_seen = 0;
  logic [399:0] exp_state, last_wr_state;
  logic [7:0]   exp_ctrl, last_wr_ctrl;

  logic         wr_pend = 1'b0;
  logic [399:0] wr_state;
  logic [7:0]   wr_ctrl;

  keccak_p400_engine #(.MAX_ROUNDS(20)) dut (
    .i_common_clk     (clk),
    .i_common_rst_n   (rst_n),
    .i_v_state_in     (mem_state),
    .i_v_ctrl_reg     (mem_ctrl),
    .i_v_num_rounds   (mem_nr),
    .i_cpu_wr_busy    (cpu_busy),
    .o_b_wr           (o_b_wr),
    .o_v_state_out    (o_v_state_out),
    .o_v_ctrl_reg_out (o_v_ctrl_reg_out),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic rc_bit(input int t);
    logic [8:0] r;
    if (t % 255 == 0) return 1'b1;
    r = 9'b000000001;
    for (int i = 1; i <= t % 255; i++) begin
      r = {r[7:0], 1'b0};
      r[0] = r[0] ^ r[8];
      r[4] = r[4] ^ r[8];
      r[5] = r[5] ^ r[8];
      r[6] = r[6] ^ r[8];
      r[8] = 1'b0;
    end
    return r[0];
  endfunction

  function automatic logic [15:0] rc_lane(input int ir);
    logic [15:0] v;
    v = '0;
    for (int j = 0; j < 5; j++) v[(1 << j) - 1] = rc_bit(j + 7 * ir);
    return v;
  endfunction

  function automatic int rho_off(input int x, input int y);
    int cx, cy, nx;
    if (x == 0 && y == 0) return 0;
    cx = 1; cy = 0;
    for (int t = 0; t < 24; t++) begin
      if (cx == x && cy == y) return ((t + 1) * (t + 2) / 2) % 16;
      nx = cy;
      cy = (2 * cx + 3 * cy) % 5;
      cx = nx;
    end
    return 0;
  endfunction

  function automatic logic [15:0] rl(input logic [15:0] v, input int n);
    logic [31:0] t;
    t = {v, v} << n;
    return t[31:16];
  endfunction

  function automatic logic [399:0] permute(input logic [399:0] s, input int nr);
    logic [15:0] a [5][5];
    logic [15:0] b [5][5];
    logic [15:0] c [5];
    logic [15:0] d [5];
    logic [399:0] r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) a[x][y] = s[16*(5*y+x) +: 16];
    for (int ir = 20 - nr; ir < 20; ir++) begin
      for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
      for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rl(c[(x+1)%5], 1);
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++) b[y][(2*x+3*y)%5] = rl(a[x][y] ^ d[x], rho_off(x, y));
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++) a[x][y] = b[x][y] ^ (~b[(x+1)%5][y] & b[(x+2)%5][y]);
      a[0][0] = a[0][0] ^ rc_lane(ir);
    end
    r = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) r[16*(5*y+x) +: 16] = a[x][y];
    return r;
  endfunction

  function automatic logic [399:0] rand_state();
    logic [399:0] s;
    for (int i = 0; i < 25; i++) s[16*i +: 16] = 16'($urandom);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- memory model and port-A busy driver ----------------
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (wr_pend) begin
      mem_state = wr_state;
      mem_ctrl  = wr_ctrl;
      wr_pend   = 1'b0;
    end
    cpu_busy = (cyc >= stall_from) && (cyc < stall_from + stall_cnt);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic eb, ew;
    if (checking) begin
      eb = (cyc >= exp_from) && (cyc <= exp_to);
      ew = (cyc == exp_wr);
      chk("busy", 400'(o_busy), 400'(eb));
      chk("b_wr", 400'(o_b_wr), 400'(ew));
      if (o_b_wr === 1'b1 && ew) begin
        chk("wr_state", o_v_state_out, exp_state);
        chk("wr_ctrl", 400'(o_v_ctrl_reg_out), 400'(exp_ctrl));
        last_wr_state = o_v_state_out;
        last_wr_ctrl  = o_v_ctrl_reg_out;
        wr_seen++;
      end
    end
    wr_pend  = (o_b_wr === 1'b1);
    wr_state = o_v_state_out;
    wr_ctrl  = o_v_ctrl_reg_out;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input logic [399:0] st, input logic [7:0] nrin,
                          input logic [7:0] ctrl_hi, input int stalls);
    int nr;
    step();
    nr = (nrin > 8'd20) ? 20 : int'(nrin);
    op_t       = cyc;
    mem_state  = st;
    mem_nr     = nrin;
    exp_state  = permute(st, nr);
    exp_ctrl   = {ctrl_hi[7:2], 2'b10};
    exp_from   = op_t + 1;
    exp_wr     = op_t + 1 + nr + stalls;
    exp_to     = exp_wr;
    stall_from = op_t + 1 + nr;
    stall_cnt  = stalls;
    mem_ctrl   = {ctrl_hi[7:2], 2'b01};
  endtask

  task automatic wait_op(input string nm);
    int seen0;
    seen0 = wr_seen;
    for (int k = 0; k < 200 && wr_seen == seen0; k++) @(posedge clk);
    #2;
    chk({nm, "_write_seen"}, 400'(wr_seen - seen0), 400'(1));
    chk({nm, "_mem_state"}, mem_state, exp_state);
    chk({nm, "_start_clear"}, 400'(mem_ctrl[0]), 400'(0));
    step();
    step();
  endtask

  task automatic run_op(input string nm, input logic [399:0] st, input logic [7:0] nrin,
                        input logic [7:0] ctrl_hi, input int stalls);
    start_op(st, nrin, ctrl_hi, stalls);
    wait_op(nm);
  endtask

  initial begin
    logic [399:0] s, r20;
    rst_n     = 1'b0;
    mem_state = '0;
    mem_ctrl  = '0;
    mem_nr    = '0;
    repeat (3) step();
    chk("rst_b_wr", 400'(o_b_wr), 400'(0));
    chk("rst_busy", 400'(o_busy), 400'(0));
    chk("rst_state", o_v_state_out, 400'(0));
    chk("rst_ctrl", 400'(o_v_ctrl_reg_out), 400'(8'h02));
    rst_n = 1'b1;
    checking = 1'b1;
    step();

    // Pin derived model constants to known values.
    chk("model_rc0", 400'(rc_lane(0)), 400'(16'h0001));
    chk("model_rc2", 400'(rc_lane(2)), 400'(16'h808A));
    chk("model_rc19", 400'(rc_lane(19)), 400'(16'h000A));
    chk("model_rho20", 400'(rho_off(2, 0)), 400'(14));

    // Zero state, one round: only iota with RC[19] survives.
    run_op("zero1", '0, 8'd1, 8'h00, 0);
    chk("zero1_lane00", 400'(last_wr_state[15:0]), 400'(16'h000A));
    chk("zero1_rest", 400'(last_wr_state[399:16]), 400'(0));
    chk("zero1_ctrl", 400'(last_wr_ctrl), 400'(8'h02));
    chk("zero1_lat", 400'(exp_wr - op_t), 400'(2));

    s = rand_state();
    run_op("nr0", s, 8'd0, 8'hA4, 0);
    chk("nr0_unchanged", last_wr_state, s);
    chk("nr0_ctrl_bits", 400'(last_wr_ctrl[1:0]), 400'(2'b10));

    s = rand_state();
    run_op("nr20", s, 8'd20, 8'h00, 0);
    r20 = last_wr_state;
    run_op("nr200", s, 8'd200, 8'h00, 0);
    chk("clamp_equal", last_wr_state, r20);

    run_op("stall3", rand_state(), 8'd5, 8'h40, 3);

    // Upper control bits are sampled in the write cycle, not at start.
    start_op(rand_state(), 8'd20, 8'h2C, 0);
    while (cyc < op_t + 2) step();
    mem_ctrl = {6'b000101, 2'b01};
    exp_ctrl = 8'h16;
    wait_op("ctrl_live");
    chk("ctrl_live_lit", 400'(last_wr_ctrl), 400'(8'h16));

    // Reset in the middle of the rounds aborts without write-back, then restarts.
    s = rand_state();
    start_op(s, 8'd20, 8'h00, 0);
    while (cyc < op_t + 11) step();
    rst_n  = 1'b0;
    exp_to = cyc;
    exp_wr = -1;
    step();
    chk("abort_busy", 400'(o_busy), 400'(0));
    chk("abort_b_wr", 400'(o_b_wr), 400'(0));
    step();
    rst_n    = 1'b1;
    op_t     = cyc;
    exp_from = op_t + 1;
    exp_wr   = op_t + 21;
    exp_to   = exp_wr;
    wait_op("restart");

    for (int i = 0; i < 8; i++) begin
      run_op("rand", rand_state(), 8'($urandom_range(0, 26)),
             8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
